delay_corr_energy_window: RTL

- Preamble-detection front end of the OFDM receiver.
- Consumes the baseband I/Q sample stream and computes, per sample:
  - the sliding-window sum of the lag-16 delayed autocorrelation magnitude;
  - the sliding-window sum of sample energy.
- Emits both as aligned 21-bit fixed-point values with enables, directly into the frame-finding stage (SumDelayCorrelation / SumMagnituder inputs).

---
 rtl/delay_corr_energy_window_pkg.sv | 19 +
 rtl/delay_corr_energy_window_if.sv | 25 ++
 rtl/delay_corr_energy_window_sliding_window_acc.sv | 34 +++
 rtl/delay_corr_energy_window.sv | 134 +++++++++++++
 4 files changed

// File: rtl/delay_corr_energy_window_pkg.sv
// Shared constants and types for the preamble-detection delay-correlation / energy front end.
package delay_corr_energy_window_pkg;

    localparam int DELAY_DEF  = 16;
    localparam int WINDOW_DEF = 16;
    localparam int IQ_W       = 8;
    localparam int SUM_W      = 21;
    localparam int FRAC_IN    = 6;
    localparam int FRAC_OUT   = 12;

    // Signed Q8.12 window sum handed to the frame-finding stage
    typedef logic signed [SUM_W-1:0] SumT;

    typedef struct packed {
        logic signed [IQ_W-1:0] re;
        logic signed [IQ_W-1:0] im;
    } IqSampleT;

endpackage

// File: rtl/delay_corr_energy_window_if.sv
// Sample-in / window-sums-out bundle between the baseband source and the frame finder.
interface delay_corr_energy_window_if;
    import delay_corr_energy_window_pkg::*;

    logic                   DataInEnable;
    logic signed [IQ_W-1:0] DataInRe;
    logic signed [IQ_W-1:0] DataInIm;
    logic                   SumDelayCorrelationEnable;
    SumT                    SumDelayCorrelation;
    logic                   SumMagnituderEnable;
    SumT                    SumMagnituder;

    modport master (
        output DataInEnable, DataInRe, DataInIm,
        input  SumDelayCorrelationEnable, SumDelayCorrelation,
        input  SumMagnituderEnable, SumMagnituder
    );

    modport slave (
        input  DataInEnable, DataInRe, DataInIm,
        output SumDelayCorrelationEnable, SumDelayCorrelation,
        output SumMagnituderEnable, SumMagnituder
    );

endinterface

// File: rtl/delay_corr_energy_window_sliding_window_acc.sv
// DEPTH-deep history plus running sum: adds the newest term and drops the one leaving the window.
module sliding_window_acc #(
    parameter int DEPTH = 16,
    parameter int IN_W  = 17,
    parameter int ACC_W = 21
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    clear,
    input  logic                    advance,
    input  logic signed [IN_W-1:0]  newTerm,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [IN_W-1:0]  history [DEPTH];
    logic signed [ACC_W-1:0] newExt;
    logic signed [ACC_W-1:0] oldExt;

    assign newExt = $signed({{(ACC_W-IN_W){newTerm[IN_W-1]}}, newTerm});
    assign oldExt = $signed({{(ACC_W-IN_W){history[DEPTH-1][IN_W-1]}}, history[DEPTH-1]});

    // History starts at zero, so the sum is exact from the very first term
    always_ff @(posedge Clk) begin
        if (!Rst_n || clear) begin
            for (int i = 0; i < DEPTH; i++) history[i] <= '0;
            acc <= '0;
        end else if (advance) begin
            history[0] <= newTerm;
            for (int i = 1; i < DEPTH; i++) history[i] <= history[i-1];
            acc <= acc + newExt - oldExt;
        end
    end

endmodule

// File: rtl/delay_corr_energy_window.sv
// Lag-DELAY autocorrelation and energy window sums for OFDM preamble detection, 3-stage pipeline.
// Optional idle-gap flush of all state is built when DC_GAP_FLUSH_EN is defined.
module delay_corr_energy_window
    import delay_corr_energy_window_pkg::*;
#(
    parameter int DELAY  = DELAY_DEF,
    parameter int WINDOW = WINDOW_DEF,
    parameter int DW     = IQ_W,
    parameter int OW     = SUM_W
`ifdef DC_GAP_FLUSH_EN
    ,
    parameter int GAP_LIMIT = 64
`endif
) (
    input logic                        Clk,
    input logic                        Rst_n,
    delay_corr_energy_window_if.slave  bus
);

    localparam int PW     = 2*DW + 1;
    localparam int ALIGN  = FRAC_OUT - 2*FRAC_IN;
    localparam int FILL_W = $clog2(DELAY + WINDOW + 1);
    localparam logic [FILL_W-1:0] FILL_DELAY = FILL_W'(DELAY);
    localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(DELAY + WINDOW - 1);
    localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(DELAY + WINDOW);

    logic accept;
    logic flush;

    IqSampleT          delayLine [DELAY];
    logic [FILL_W-1:0] fillCount;
    logic              useDelayed;

    logic signed [PW-1:0] aX, bX, cX, dX;
    logic signed [PW-1:0] pReNext, pImNext, eNext;
    logic signed [PW-1:0] pRe, pIm, e;
    logic                 s1Valid, s1Full;
    logic                 s2Valid;

    logic signed [OW-1:0] cRe, cIm, eAcc;
    logic [OW-1:0]        absRe, absIm;

    assign accept = bus.DataInEnable;

`ifdef DC_GAP_FLUSH_EN
    localparam int IDLE_W = $clog2(GAP_LIMIT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(GAP_LIMIT - 1);

    logic [IDLE_W-1:0] idleCount;

    // A long silence means the burst is over; start the next one from an empty window
    always_ff @(posedge Clk) begin
        if (!Rst_n || accept || flush) idleCount <= '0;
        else                           idleCount <= idleCount + 1'b1;
    end

    assign flush = !accept && (idleCount == IDLE_LAST);
`else
    assign flush = 1'b0;
`endif

    // Until DELAY samples are stored there is no partner sample, so the product counts as zero
    assign useDelayed = (fillCount >= FILL_DELAY);

    assign aX = $signed({{(PW-DW){bus.DataInRe[DW-1]}}, bus.DataInRe});
    assign bX = $signed({{(PW-DW){bus.DataInIm[DW-1]}}, bus.DataInIm});
    assign cX = useDelayed ? $signed({{(PW-DW){delayLine[DELAY-1].re[DW-1]}}, delayLine[DELAY-1].re}) : '0;
    assign dX = useDelayed ? $signed({{(PW-DW){delayLine[DELAY-1].im[DW-1]}}, delayLine[DELAY-1].im}) : '0;

    assign pReNext = aX*cX + bX*dX;
    assign pImNext = bX*cX - aX*dX;
    assign eNext   = aX*aX + bX*bX;

    always_ff @(posedge Clk) begin
        if (!Rst_n || flush) begin
            for (int i = 0; i < DELAY; i++) delayLine[i] <= '0;
            fillCount <= '0;
            pRe       <= '0;
            pIm       <= '0;
            e         <= '0;
            s1Valid   <= 1'b0;
            s1Full    <= 1'b0;
        end else begin
            s1Valid <= accept;
            if (accept) begin
                delayLine[0] <= '{re: bus.DataInRe, im: bus.DataInIm};
                for (int i = 1; i < DELAY; i++) delayLine[i] <= delayLine[i-1];
                if (fillCount != FILL_MAX) fillCount <= fillCount + 1'b1;
                s1Full <= (fillCount >= FILL_LAST);
                pRe    <= pReNext <<< ALIGN;
                pIm    <= pImNext <<< ALIGN;
                e      <= eNext <<< ALIGN;
            end
        end
    end

    sliding_window_acc #(.DEPTH(WINDOW), .IN_W(PW), .ACC_W(OW)) accRe (
        .Clk(Clk), .Rst_n(Rst_n), .clear(flush), .advance(s1Valid), .newTerm(pRe), .acc(cRe)
    );

    sliding_window_acc #(.DEPTH(WINDOW), .IN_W(PW), .ACC_W(OW)) accIm (
        .Clk(Clk), .Rst_n(Rst_n), .clear(flush), .advance(s1Valid), .newTerm(pIm), .acc(cIm)
    );

    sliding_window_acc #(.DEPTH(WINDOW), .IN_W(PW), .ACC_W(OW)) accEnergy (
        .Clk(Clk), .Rst_n(Rst_n), .clear(flush), .advance(s1Valid), .newTerm(e), .acc(eAcc)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n || flush) s2Valid <= 1'b0;
        else                 s2Valid <= s1Valid && s1Full;
    end

    assign absRe = cRe[OW-1] ? $unsigned(-cRe) : $unsigned(cRe);
    assign absIm = cIm[OW-1] ? $unsigned(-cIm) : $unsigned(cIm);

    // Output data only moves on a valid result, so consumers see it hold between pulses
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            bus.SumDelayCorrelationEnable <= 1'b0;
            bus.SumMagnituderEnable       <= 1'b0;
            bus.SumDelayCorrelation       <= '0;
            bus.SumMagnituder             <= '0;
        end else begin
            bus.SumDelayCorrelationEnable <= s2Valid;
            bus.SumMagnituderEnable       <= s2Valid;
            if (s2Valid) begin
                bus.SumDelayCorrelation <= $signed(absRe + absIm);
                bus.SumMagnituder       <= eAcc;
            end
        end
    end

endmodule
